// File: rtl/muldiv_unit_param_if.sv
// HI/LO multiply/divide command and result bundle.
// master drives commands and abort; slave returns busy, done pulses and HI/LO.
interface muldiv_unit_param_if #(
  parameter int WIDTH = 32
);
  logic             cmd_valid;
  logic [2:0]       cmd_op;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic             abort;
  logic             busy;
  logic             done;
  logic             div_zero;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output cmd_valid, cmd_op, op_a, op_b, abort,
    input  busy, done, div_zero, hi, lo
  );

  modport slave (
    input  cmd_valid, cmd_op, op_a, op_b, abort,
    output busy, done, div_zero, hi, lo
  );
endinterface

// File: rtl/muldiv_unit_param.sv
// HI/LO mult/div: multiply writes MUL_LAT edges after accept, divide WIDTH/DIV_STEP+2 edges.
// No backpressure: commands always accepted; busy stalls HI/LO readers, abort or a newer command cancels.
module muldiv_unit_param #(
  parameter int WIDTH    = 32,
  parameter int MUL_LAT  = 3,
  parameter int DIV_STEP = 1
) (
  input logic                 clk,
  input logic                 rst_n,
  muldiv_unit_param_if.slave  bus
);

  localparam int DIV_ITER = WIDTH / DIV_STEP;
  localparam int CNT_MAX  = (DIV_ITER > MUL_LAT) ? DIV_ITER : MUL_LAT;
  localparam int CW       = $clog2(CNT_MAX + 1);

  localparam logic [2:0] OP_MULT  = 3'd0;
  localparam logic [2:0] OP_MULTU = 3'd1;
  localparam logic [2:0] OP_DIV   = 3'd2;
  localparam logic [2:0] OP_DIVU  = 3'd3;
  localparam logic [2:0] OP_MTHI  = 3'd4;
  localparam logic [2:0] OP_MTLO  = 3'd5;

  typedef enum logic [1:0] {IDLE, MUL, DIV, DIV_FIX} state_t;

  state_t           state, state_nxt;
  logic [CW-1:0]    cnt, cnt_nxt;
  logic             cmd_ok, is_md, is_signed;
  logic             do_iter, do_fix, wr_mul, wr_div;

  logic [WIDTH:0]   ma, mb;
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0] dq, rem, dv;
  logic             q_neg, r_neg, dz;
  logic [2*WIDTH-1:0] step_res;
  logic [WIDTH-1:0] hi_q, lo_q;
  logic             done_q, div_zero_q;

  function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] v, input logic sgn);
    return (sgn && v[WIDTH-1]) ? (~v + 1'b1) : v;
  endfunction

  // Restoring division, DIV_STEP single-bit steps per clock; a zero divisor yields all-ones quotient.
  function automatic logic [2*WIDTH-1:0] div_steps(input logic [WIDTH-1:0] r_in,
                                                    input logic [WIDTH-1:0] q_in,
                                                    input logic [WIDTH-1:0] d);
    logic [WIDTH:0]   t;
    logic [WIDTH-1:0] rr;
    logic [WIDTH-1:0] qq;
    rr = r_in;
    qq = q_in;
    for (int i = 0; i < DIV_STEP; i++) begin
      t  = {rr, qq[WIDTH-1]};
      qq = {qq[WIDTH-2:0], 1'b0};
      if (t >= {1'b0, d}) begin
        t     = t - {1'b0, d};
        qq[0] = 1'b1;
      end
      rr = t[WIDTH-1:0];
    end
    return {rr, qq};
  endfunction

  assign cmd_ok    = bus.cmd_valid && !bus.abort && (bus.cmd_op <= OP_MTLO);
  assign is_md     = cmd_ok && (bus.cmd_op <= OP_DIVU);
  assign is_signed = (bus.cmd_op == OP_MULT) || (bus.cmd_op == OP_DIV);
  assign step_res  = div_steps(rem, dq, dv);
  // Low 2W bits of the (W+1)-bit extended product are all that reach HI/LO.
  assign prod      = {{(WIDTH-1){ma[WIDTH]}}, ma} * {{(WIDTH-1){mb[WIDTH]}}, mb};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    do_iter   = 1'b0;
    do_fix    = 1'b0;
    wr_mul    = 1'b0;
    wr_div    = 1'b0;
    if (bus.abort) begin
      state_nxt = IDLE;
      cnt_nxt   = '0;
    end else if (cmd_ok) begin
      case (bus.cmd_op)
        OP_MULT, OP_MULTU: begin
          state_nxt = MUL;
          cnt_nxt   = CW'(MUL_LAT - 1);
        end
        OP_DIV, OP_DIVU: begin
          state_nxt = DIV;
          cnt_nxt   = CW'(DIV_ITER);
        end
        default: begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end
      endcase
    end else begin
      case (state)
        MUL: begin
          if (cnt == '0) begin
            wr_mul    = 1'b1;
            state_nxt = IDLE;
          end else begin
            cnt_nxt = cnt - CW'(1);
          end
        end
        DIV: begin
          if (cnt == '0) begin
            do_fix    = 1'b1;
            state_nxt = DIV_FIX;
          end else begin
            do_iter = 1'b1;
            cnt_nxt = cnt - CW'(1);
          end
        end
        DIV_FIX: begin
          wr_div    = 1'b1;
          state_nxt = IDLE;
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hi_q       <= '0;
      lo_q       <= '0;
      done_q     <= 1'b0;
      div_zero_q <= 1'b0;
      ma         <= '0;
      mb         <= '0;
      dq         <= '0;
      rem        <= '0;
      dv         <= '0;
      q_neg      <= 1'b0;
      r_neg      <= 1'b0;
      dz         <= 1'b0;
    end else begin
      done_q     <= 1'b0;
      div_zero_q <= 1'b0;
      if (cmd_ok) begin
        case (bus.cmd_op)
          OP_MULT, OP_MULTU: begin
            ma <= {is_signed & bus.op_a[WIDTH-1], bus.op_a};
            mb <= {is_signed & bus.op_b[WIDTH-1], bus.op_b};
          end
          OP_DIV, OP_DIVU: begin
            dq    <= mag(bus.op_a, is_signed);
            dv    <= mag(bus.op_b, is_signed);
            rem   <= '0;
            q_neg <= is_signed && (bus.op_a[WIDTH-1] ^ bus.op_b[WIDTH-1]);
            r_neg <= is_signed && bus.op_a[WIDTH-1];
            dz    <= (bus.op_b == '0);
          end
          OP_MTHI: hi_q <= bus.op_a;
          OP_MTLO: lo_q <= bus.op_a;
          default: ;
        endcase
      end
      if (do_iter) begin
        rem <= step_res[2*WIDTH-1:WIDTH];
        dq  <= step_res[WIDTH-1:0];
      end
      if (do_fix) begin
        dq  <= q_neg ? -dq : dq;
        rem <= r_neg ? -rem : rem;
      end
      if (wr_mul) begin
        hi_q   <= prod[2*WIDTH-1:WIDTH];
        lo_q   <= prod[WIDTH-1:0];
        done_q <= 1'b1;
      end
      if (wr_div) begin
        hi_q       <= rem;
        lo_q       <= dq;
        done_q     <= 1'b1;
        div_zero_q <= dz;
      end
    end
  end

  assign bus.busy     = is_md || (state != IDLE);
  assign bus.done     = done_q;
  assign bus.div_zero = div_zero_q;
  assign bus.hi       = hi_q;
  assign bus.lo       = lo_q;

endmodule

// File: doc/muldiv_unit_param.md
Name: muldiv_unit_param

Overview:
Parametrised HI/LO multiply/divide unit for the R3000-class execute stage. It is the next-generation replacement for the fixed 32-bit muldiv block. New capabilities over that block:
- configurable operand width and multiply latency
- integrated iterative divider with selectable bits per cycle
- MIPS divide-by-zero and overflow semantics
- pipeline abort for exceptions
- explicit completion pulse

Parameters:
WIDTH, 32, operand and HI/LO width; even, >=8
MUL_LAT, 3, multiply latency in clocks from acceptance edge to HI/LO write; >=1
DIV_STEP, 1, quotient bits retired per clock (1 or 2); WIDTH % DIV_STEP == 0

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
cmd_valid  in  1  command present this cycle
cmd_op  in  3  0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO, 6/7 ignored
op_a  in  WIDTH  rs operand (dividend / MTxx source)
op_b  in  WIDTH  rt operand (divisor)
abort  in  1  kill in-flight op and any command this cycle
busy  out  1  HI/LO not readable; stall mfhi/mflo
done  out  1  one-cycle pulse, HI/LO just updated by mult/div
div_zero  out  1  one-cycle pulse with done when divisor was zero
hi  out  WIDTH  HI register
lo  out  WIDTH  LO register

Behaviour:
- Reset: rst_n is asynchronous, active-low; clock is clk. On reset: hi=0, lo=0, done=0, div_zero=0, state IDLE, all counters 0. Reset mid-operation discards the operation with no HI/LO write.
- States: IDLE, MUL, DIV, DIV_FIX. Edge at which a command is accepted = E0.
- Acceptance: any cmd_valid with op 0-5 and abort=0 is accepted regardless of state. A new mult/div or MTxx cancels any in-flight op; the cancelled op never writes HI/LO and never pulses done.
- MTHI/MTLO: write op_a into hi/lo at E0; the other register is unchanged; state goes to IDLE; no done pulse.
- MULT/MULTU:
  - Operands are extended to WIDTH+1 bits (sign-extended for MULT, zero-extended for MULTU); the product is 2*WIDTH+2 bits.
  - Operands are captured at E0. State MUL counts MUL_LAT.
  - At edge E0+MUL_LAT: hi = product[2W-1:W], lo = product[W-1:0]; done=1 for one cycle; state IDLE.
- DIV/DIVU:
  - E0: capture the magnitudes (abs for DIV) and sign flags.
  - State DIV runs WIDTH/DIV_STEP restoring-division iterations.
  - DIV_FIX applies signs: quotient negated if operand signs differ; remainder takes the dividend's sign.
  - hi/lo and done are written at edge E0+WIDTH/DIV_STEP+2. With the defaults that is E0+34.
  - Results: lo = quotient, hi = remainder.
- Divide by zero:
  - Full latency still applies; div_zero pulses with done; hi = op_a.
  - lo = all-ones for DIVU, or for DIV with op_a >= 0. lo = 1 for DIV with op_a < 0.
- Signed overflow: DIV with most-negative / -1 gives lo = most-negative, hi = 0, with no flag.
- busy:
  - Combinationally high when cmd_valid and cmd_op is 0-3 and abort=0.
  - Otherwise registered high while state != IDLE.
  - Low in the done cycle, so the new hi/lo are readable that cycle.
- abort:
  - Highest priority. It returns the state to IDLE at the next edge, drops any same-cycle command (including MTxx), and blocks the HI/LO write.
  - If the op would complete at that edge, the write is still blocked.
  - busy is low in the cycle after the abort.
- A command in the final cycle before completion cancels the old op; only the new op completes.
- done and div_zero are never high in the same cycle as reset release or outside a completion.

Test Plan:
- MULT op_a=-3 (FFFFFFFD), op_b=7, defaults -> at E0+3: hi=FFFFFFFF, lo=FFFFFFEB, done 1 cycle, busy high in cycles E0-1..E0+2.
- MULTU FFFFFFFF x FFFFFFFF -> hi=FFFFFFFE, lo=00000001 at E0+3.
- MULTU, WIDTH=16, MUL_LAT=1: FFFF x FFFF -> hi=FFFE, lo=0001 at E0+1.
- DIV -7 / 2 -> lo=FFFFFFFD, hi=FFFFFFFF at E0+34.
- DIV 80000000 / FFFFFFFF -> lo=80000000, hi=0.
- DIV, DIV_STEP=2: same divides complete at E0+18 with the same values.
- DIV 5 / 0 -> lo=FFFFFFFF, hi=5, div_zero and done together.
- DIV -5 / 0 -> lo=1, hi=FFFFFFFB.
- DIVU 5 / 0 -> lo=FFFFFFFF.
- Start DIV 100/7; at E0+10 assert abort -> hi/lo keep prior values (preload with MTHI/MTLO 0xA5A5A5A5), no done, busy low at E0+12.
- Abort with cmd_valid MTLO in the same cycle -> lo unchanged.
- During MULT, issue MTLO 0x1234 at E0+1 -> lo=0x1234 at E0+2, hi unchanged, no done ever for the mult.
- Assert rst_n low mid-DIV -> hi=lo=0 immediately (asynchronous), busy=0, no done after release.
